// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the shared external ALU: owns a small register file,
// drives ALU operands from it, captures the result and flags, then writes back.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int FLAGW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [1:0]               instr_kind,
  input  logic [7:0]               instr_opcode,
  input  logic                     instr_use_c,
  input  logic [$clog2(NREGS)-1:0] instr_dst,
  input  logic [$clog2(NREGS)-1:0] instr_src1,
  input  logic [$clog2(NREGS)-1:0] instr_src2,
  input  logic [WIDTH-1:0]         instr_imm,
  output logic [WIDTH-1:0]         alu_r1,
  output logic [WIDTH-1:0]         alu_r2,
  output logic [7:0]               alu_opcode,
  output logic                     alu_cin,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic [FLAGW-1:0]         alu_flags,
  output logic [FLAGW-1:0]         flags,
  output logic [WIDTH-1:0]         disp_val,
  output logic                     done
);

  localparam int IW = $clog2(NREGS);

  // state | meaning
  // IDLE  | ready, accept one instruction
  // EXEC  | ALU inputs held stable; result and flags captured on exit
  // WB    | write result to reg[dst] and display, pulse done
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;
  logic [7:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic [FLAGW-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic [IW-1:0]    dst_q, dst_d;
  logic             accept;

  assign accept = instr_valid && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (instr_kind == 2'b00)      state_d = S_EXEC;
          else if (instr_kind == 2'b01) state_d = S_WB;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    done        = (state_q == S_WB);
  end

  always_comb begin
    regs_d    = regs_q;
    alu_r1_d  = alu_r1_q;
    alu_r2_d  = alu_r2_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    flags_d   = flags_q;
    result_d  = result_q;
    disp_d    = disp_q;
    dst_d     = dst_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (instr_kind)
            2'b00: begin
              alu_r1_d  = regs_q[instr_src1];
              alu_r2_d  = regs_q[instr_src2];
              alu_op_d  = instr_opcode;
              alu_cin_d = instr_use_c & flags_q[0];
              dst_d     = instr_dst;
            end
            2'b01: begin
              result_d = instr_imm;
              dst_d    = instr_dst;
            end
            2'b10: ;
            2'b11: flags_d = '0;
          endcase
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        flags_d  = alu_flags;
      end
      S_WB: begin
        regs_d[dst_q] = result_q;
        disp_d        = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      alu_r1_q  <= '0;
      alu_r2_q  <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      flags_q   <= '0;
      result_q  <= '0;
      disp_q    <= '0;
      dst_q     <= '0;
    end else begin
      regs_q    <= regs_d;
      alu_r1_q  <= alu_r1_d;
      alu_r2_q  <= alu_r2_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      flags_q   <= flags_d;
      result_q  <= result_d;
      disp_q    <= disp_d;
      dst_q     <= dst_d;
    end
  end

  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_opcode = alu_op_q;
  assign alu_cin    = alu_cin_q;
  assign flags      = flags_q;
  assign disp_val   = disp_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the shared 16-bit ALU for the CPU top level. It accepts one instruction at a time over a valid/ready handshake and reads operands from a 4-entry x 16-bit register file it owns. It drives the ALU operand, opcode and carry-in inputs, captures the ALU result and flags, and writes the result back. The last written value goes to the seven-segment display path; the ALU itself stays external and combinational.

Parameters:
WIDTH, 16, datapath/register width
NREGS, 4, register file depth (register index width = 2)
FLAGW, 4, ALU flag width; bit 0 = carry

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept
instr_kind  in  2  00 ALU op, 01 load immediate, 10 NOP, 11 clear flags
instr_opcode  in  8  ALU opcode (kind 00)
instr_use_c  in  1  kind 00: drive alu_cin from stored carry, else 0
instr_dst  in  2  destination register
instr_src1  in  2  operand 1 register
instr_src2  in  2  operand 2 register
instr_imm  in  WIDTH  immediate (kind 01)
alu_r1  out  WIDTH  ALU operand 1
alu_r2  out  WIDTH  ALU operand 2
alu_opcode  out  8  ALU opcode
alu_cin  out  1  ALU carry-in
alu_out  in  WIDTH  ALU result (combinational from alu_* outputs)
alu_flags  in  FLAGW  ALU flags
flags  out  FLAGW  stored flags
disp_val  out  WIDTH  last written-back value, feeds the four hex digits
done  out  1  one-cycle pulse in the write-back cycle

Behaviour:
- Reset, checked first every cycle: state IDLE; all registers 0; flags 0; disp_val 0; alu_r1/alu_r2/alu_opcode/alu_cin 0; done 0; instr_ready 1. Reset during any state aborts the instruction with no write-back.
- Handshake: transfer on a rising edge with instr_valid && instr_ready. instr_ready = 1 only in IDLE. Inputs are sampled only at the transfer edge and may change afterward.
- States: IDLE, EXEC, WB.
- IDLE, kind 00 accepted: register alu_r1 = reg[src1], alu_r2 = reg[src2], alu_opcode, alu_cin = use_c ? flags[0] : 0, and latch dst. Next state EXEC.
- EXEC: ALU inputs held stable. On exit, capture alu_out into the result register and alu_flags into flags. Next state WB.
- IDLE, kind 01 accepted: result = imm, latch dst, flags unchanged. Next state WB, skipping EXEC.
- IDLE, kind 10 accepted: no state change, stay in IDLE, no done pulse.
- IDLE, kind 11 accepted: flags cleared to 0 on that edge, stay in IDLE, no done pulse.
- WB: reg[dst] <= result; disp_val <= result; done = 1 for this cycle only. Next state IDLE.
- Latency: ALU op accepted at edge N -> EXEC during cycle N+1, WB (done) during cycle N+2, register visible and ready high from N+3. Load immediate: WB at N+1, ready at N+2.
- Back-to-back: an instruction accepted in the IDLE cycle right after WB reads the freshly written register value.
- src1 == src2 == dst is legal; operands are read before write-back.
- Arithmetic is entirely the ALU's. The sequencer does no width extension. The carry chain uses only flags[0].
- alu_* outputs keep their last values in IDLE; they are not zeroed.
- Flags update only on an ALU op or on kind 11.

Test Plan:
- Bench ALU model: opcode 8'h01 = add with cin, 8'h02 = and, flags[0] = carry-out.
- Reset then idle: instr_ready = 1, disp_val = 16'h0000, flags = 0, done = 0.
- LDI r0 = 16'h8FFF, LDI r1 = 16'h0001, ADD r2 = r0 + r1 (op 01, use_c = 0) -> done 2 cycles after ADD accept; r2 = 16'h9000; disp_val = 16'h9000; flags[0] = 0.
- LDI r0 = 16'hFFFF, r1 = 16'h0001; ADD r2 = r0 + r1 -> 16'h0000 with flags[0] = 1. Then ADD r3 = r1 + r1 with use_c = 1 -> alu_cin = 1, r3 = 16'h0003.
- Hold instr_valid high continuously with four LDIs -> exactly one accept per 2 cycles; instr_ready low in WB; each done pulse is 1 cycle wide.
- Assert reset during EXEC of an ADD into r2 -> no done pulse, r2 stays 0, instr_ready = 1 the cycle after reset deasserts.
- ADD r1 = r1 + r1 with r1 = 16'h4000 -> alu_r1 = alu_r2 = 16'h4000, r1 = 16'h8000. Then kind 11 -> flags = 0, no done pulse.
